// File: rtl/mem_responder.sv
// mem_responder: fixed-latency 128-bit line memory model for a cache bench.
// A request is accepted in IDLE, waits out LATENCY cycles, performs the
// read or write, pulses mem_ready for one cycle, then spends one cycle in
// RECOVER before it can accept another request.
// Optional feature: define MEM_RESPONDER_STAT_EN to add the 32-bit
// rd_count / wr_count completion counters.
module mem_responder #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned DEPTH_BITS = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [27:0]  mem_addr,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_ready
`ifdef MEM_RESPONDER_STAT_EN
  ,
  output logic [31:0]  rd_count,
  output logic [31:0]  wr_count
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_BITS;

  // Cycle budget spent in BUSY: accept edge and the RESP edge account for
  // the other two of the LATENCY edges; LATENCY=1 bypasses BUSY entirely.
  localparam logic [7:0] CNT_LOAD = (LATENCY >= 2) ? 8'(LATENCY - 2) : 8'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESP    = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [DEPTH_BITS-1:0]   idx_q, idx_d;
  logic [127:0]            wdata_q, wdata_d;
  logic                    is_wr_q, is_wr_d;
  logic                    ready_q, ready_d;
  logic [127:0]            rdata_q;

  // Backing store; deliberately not reset so contents survive reset_n.
  logic [127:0]            mem_q [DEPTH];

  // High address bits only alias; they never select storage.
  generate
    if (DEPTH_BITS < 28) begin : g_addr_unused
      logic unused_addr_hi;
      assign unused_addr_hi = ^mem_addr[27:DEPTH_BITS];
    end
  endgenerate

  // Next-state, request latching and latency countdown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          idx_d   = mem_addr[DEPTH_BITS-1:0];
          wdata_d = mem_wdata;
          is_wr_d = mem_write;          // write wins when both are high
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY <= 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 8'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        ready_d = 1'b1;                 // pulse lands in the following cycle
        state_d = RECOVER;
      end
      RECOVER: begin
        state_d = IDLE;                 // requests ignored for this cycle
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and latch registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      ready_q <= ready_d;
    end
  end

  // Storage write on the completion edge of a write transaction.
  always_ff @(posedge clk) begin
    if (state_q == RESP && is_wr_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  // Registered read data, loaded on the completion edge of a read only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (state_q == RESP && !is_wr_q) begin
      rdata_q <= mem_q[idx_q];
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;

`ifdef MEM_RESPONDER_STAT_EN
  logic [31:0] rd_count_q;
  logic [31:0] wr_count_q;

  // Completion counters, free-running with natural 32-bit wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_count_q <= 32'd0;
      wr_count_q <= 32'd0;
    end else if (state_q == RESP) begin
      if (is_wr_q) begin
        wr_count_q <= wr_count_q + 32'd1;
      end else begin
        rd_count_q <= rd_count_q + 32'd1;
      end
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule
